// File: rtl/rect_plot_engine.sv
// Round-robin filled-rectangle plotter: serialises per-channel rectangle
// requests into a single clipped pixel stream, one pixel per clock.
module rect_plot_engine #(
  parameter int NUM_CH   = 4,
  parameter int XW       = 8,
  parameter int YW       = 7,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int DW       = 5,
  parameter int COLOUR_W = 3
) (
  input  logic                         CLOCK_50,
  input  logic                         resetn,
  input  logic [NUM_CH-1:0]            req,
  input  logic [NUM_CH*XW-1:0]         req_x,
  input  logic [NUM_CH*YW-1:0]         req_y,
  input  logic [NUM_CH*DW-1:0]         req_w,
  input  logic [NUM_CH*DW-1:0]         req_h,
  input  logic [NUM_CH*COLOUR_W-1:0]   req_colour,
  output logic [NUM_CH-1:0]            ack,
  output logic [NUM_CH-1:0]            done,
  output logic                         busy,
  output logic [XW-1:0]                x,
  output logic [YW-1:0]                y,
  output logic [COLOUR_W-1:0]          colour,
  output logic                         plot
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t              state;
  logic [CW-1:0]       rr, g, sel;
  logic                any;
  logic [XW-1:0]       x0, sx;
  logic [YW-1:0]       y0, sy;
  logic [DW-1:0]       w0, h0, sw, sh, col, row;
  logic [COLOUR_W-1:0] c0, sc;
  logic [XW:0]         px;
  logic [YW:0]         py;

  // First requester at or above the rr pointer, wrapping.
  always_comb begin
    int k;
    k   = 0;
    any = 1'b0;
    sel = '0;
    sx  = '0;
    sy  = '0;
    sw  = '0;
    sh  = '0;
    sc  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      k = (int'(rr) + i) % NUM_CH;
      if (!any && req[k]) begin
        any = 1'b1;
        sel = CW'(k);
        sx  = req_x[k*XW +: XW];
        sy  = req_y[k*YW +: YW];
        sw  = req_w[k*DW +: DW];
        sh  = req_h[k*DW +: DW];
        sc  = req_colour[k*COLOUR_W +: COLOUR_W];
      end
    end
  end

  assign px = {1'b0, x0} + (XW+1)'(col);
  assign py = {1'b0, y0} + (YW+1)'(row);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      ack    <= '0;
      done   <= '0;
      busy   <= 1'b0;
      plot   <= 1'b0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
      rr     <= '0;
      g      <= '0;
      x0     <= '0;
      y0     <= '0;
      w0     <= '0;
      h0     <= '0;
      c0     <= '0;
      col    <= '0;
      row    <= '0;
    end else begin
      ack  <= '0;
      done <= '0;
      plot <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any) begin
            ack[sel] <= 1'b1;
            g        <= sel;
            x0       <= sx;
            y0       <= sy;
            w0       <= sw;
            h0       <= sh;
            c0       <= sc;
            col      <= '0;
            row      <= '0;
            busy     <= 1'b1;
            state    <= (sw == '0 || sh == '0) ? DONE : DRAW;
          end
        end
        DRAW: begin
          plot   <= (px < (XW+1)'(SCREEN_W)) &&
                    (py < (YW+1)'(SCREEN_H));
          x      <= px[XW-1:0];
          y      <= py[YW-1:0];
          colour <= c0;
          if (col == w0 - DW'(1)) begin
            col <= '0;
            if (row == h0 - DW'(1)) state <= DONE;
            else                    row   <= row + DW'(1);
          end else begin
            col <= col + DW'(1);
          end
        end
        DONE: begin
          done[g] <= 1'b1;
          busy    <= 1'b0;
          rr      <= (g == CW'(NUM_CH-1)) ? '0 : g + CW'(1);
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rect_plot_engine.sv
// Directed and random checks of rect_plot_engine against a pixel-list
// and round-robin reference model.
module tb_rect_plot_engine;

  localparam int NC = 4;

  logic          clk;
  logic          rst_n;
  logic [NC-1:0] req;
  logic [31:0]   req_x;
  logic [27:0]   req_y;
  logic [19:0]   req_w;
  logic [19:0]   req_h;
  logic [11:0]   req_colour;
  logic [NC-1:0] ack;
  logic [NC-1:0] done;
  logic          busy;
  logic [7:0]    x;
  logic [6:0]    y;
  logic [2:0]    colour;
  logic          plot;

  int total;
  int bad;
  int m_rr;

  rect_plot_engine dut (
    .CLOCK_50   (clk),
    .resetn     (rst_n),
    .req        (req),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_w      (req_w),
    .req_h      (req_h),
    .req_colour (req_colour),
    .ack        (ack),
    .done       (done),
    .busy       (busy),
    .x          (x),
    .y          (y),
    .colour     (colour),
    .plot       (plot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int ch, input int px, input int py,
                        input int w, input int h, input int c);
    req_x[ch*8 +: 8]      = 8'(px);
    req_y[ch*7 +: 7]      = 7'(py);
    req_w[ch*5 +: 5]      = 5'(w);
    req_h[ch*5 +: 5]      = 5'(h);
    req_colour[ch*3 +: 3] = 3'(c);
  endtask

  function automatic int rr_pick(input logic [NC-1:0] m, input int p);
    for (int i = 0; i < NC; i++)
      if (m[(p + i) % NC]) return (p + i) % NC;
    return -1;
  endfunction

  task automatic wait_ack(output int waited);
    bit got;
    got = 0;
    waited = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      waited++;
      if (ack != '0) got = 1;
    end
    chk("ack_seen", 32'(got), 32'd1);
  endtask

  // Full rectangle: grant, raster pixels with clipping, done, back to idle.
  task automatic draw_one(input int ch, input int px, input int py,
                          input int w, input int h, input int c);
    int wt, ex, ey;
    bit vis;
    set_ch(ch, px, py, w, h, c);
    req[ch] = 1'b1;
    wait_ack(wt);
    chk("ack_ch", 32'(ack), 32'(1 << ch));
    chk("busy_draw", 32'(busy), 32'd1);
    req[ch] = 1'b0;
    set_ch(ch, $urandom, $urandom, $urandom, $urandom, $urandom);
    for (int n = 0; n < w * h; n++) begin
      @(negedge clk);
      ex  = px + n % w;
      ey  = py + n / w;
      vis = (ex < 160) && (ey < 120);
      chk("plot", 32'(plot), 32'(vis));
      chk("no_done_mid", 32'(done), 32'd0);
      if (vis) begin
        chk("px_x", 32'(x), 32'(ex));
        chk("px_y", 32'(y), 32'(ey));
        chk("px_col", 32'(colour), 32'(c));
      end
    end
    @(negedge clk);
    chk("done_ch", 32'(done), 32'(1 << ch));
    chk("done_plot", 32'(plot), 32'd0);
    m_rr = (ch + 1) % NC;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_plot", 32'(plot), 32'd0);
  endtask

  // Held 1x1 requests on several channels: grant order follows rr model.
  task automatic rr_run(input logic [NC-1:0] m, input int n);
    int wt, g;
    logic [NC-1:0] e;
    for (int ch = 0; ch < NC; ch++) set_ch(ch, 10 + ch, 20 + ch, 1, 1, ch);
    req = m;
    for (int k = 0; k < n; k++) begin
      wait_ack(wt);
      if (k > 0) chk("ack_after_done", 32'(wt), 32'd1);
      g = rr_pick(m, m_rr);
      e = '0;
      e[g] = 1'b1;
      chk("rr_ack", 32'(ack), 32'(e));
      @(negedge clk);
      chk("rr_plot", 32'(plot), 32'd1);
      chk("rr_x", 32'(x), 32'(10 + g));
      @(negedge clk);
      chk("rr_done", 32'(done), 32'(e));
      m_rr = (g + 1) % NC;
      if (k == n - 1) req = '0;
    end
    @(negedge clk);
    chk("rr_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int wt, r;
    total = 0;
    bad = 0;
    m_rr = 0;
    req = '0;
    req_x = '0;
    req_y = '0;
    req_w = '0;
    req_h = '0;
    req_colour = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of a rectangle aborts it silently.
    set_ch(0, 5, 110, 16, 2, 7);
    req[0] = 1'b1;
    wait_ack(wt);
    req[0] = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_plot_before", 32'(plot), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {ack, done, busy, plot, x, y, colour}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_rr = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done != '0 || plot || busy) break;
    end
    chk("post_rst_quiet", {done, plot, busy}, 32'd0);

    rr_run(4'b1010, 4);
    draw_one(0, 5, 110, 16, 2, 7);
    draw_one(2, 155, 118, 8, 4, 5);
    draw_one(0, 30, 30, 0, 5, 3);
    draw_one(1, 40, 50, 4, 1, 6);
    draw_one(3, 250, 10, 6, 2, 1);

    for (int t = 0; t < 20; t++) begin
      r = $urandom_range(0, 2);
      draw_one($urandom_range(0, NC - 1),
               (r == 0) ? $urandom_range(150, 165) : $urandom_range(0, 255),
               (r == 1) ? $urandom_range(110, 125) : $urandom_range(0, 127),
               $urandom_range(0, 7), $urandom_range(0, 4),
               $urandom_range(0, 7));
    end
    for (int t = 0; t < 6; t++) rr_run(4'($urandom_range(1, 15)), 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rect_plot_engine.md
Name: rect_plot_engine

Overview:
Parametrised multi-channel filled-rectangle plotter. It replaces the per-object draw_counter loops in the game FSM: tanks, shell, blocks and erasers each request a rectangle, and the engine serialises them into one pixel stream for vga_adapter. Channels are served round-robin, one pixel per clock. Pixels that fall off-screen are clipped and never plotted.

Parameters:
NUM_CH, 4, number of requesting channels (2..8)
XW, 8, x coordinate width
YW, 7, y coordinate width
SCREEN_W, 160, visible width; x >= SCREEN_W is clipped
SCREEN_H, 120, visible height; y >= SCREEN_H is clipped
DW, 5, width/height field width; max rectangle dimension is 2^DW-1
COLOUR_W, 3, colour width

Ports:
CLOCK_50  in  1  system clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
req  in  NUM_CH  per-channel request, level
req_x  in  NUM_CH*XW  top-left x; channel i occupies slice [i*XW +: XW]
req_y  in  NUM_CH*YW  top-left y, sliced the same way
req_w  in  NUM_CH*DW  width in pixels
req_h  in  NUM_CH*DW  height in pixels
req_colour  in  NUM_CH*COLOUR_W  fill colour
ack  out  NUM_CH  one-cycle pulse: request accepted, parameters latched
done  out  NUM_CH  one-cycle pulse: rectangle finished
busy  out  1  high in DRAW and DONE states
x  out  XW  pixel x to vga_adapter
y  out  YW  pixel y to vga_adapter
colour  out  COLOUR_W  pixel colour
plot  out  1  pixel write strobe

Behaviour:
- Reset (async, resetn=0): state IDLE; ack, done, busy, plot = 0; x, y, colour = 0; rr pointer = 0. A reset mid-rectangle aborts it with no done pulse and no further plots.
- All outputs are registered.
- States: IDLE, DRAW, DONE.
- IDLE: if any req bit is high, grant the first set bit searching from rr pointer upward, wrapping modulo NUM_CH. On that edge:
  - ack[g] = 1 for exactly one cycle;
  - latch the channel's x, y, w, h, colour;
  - column counter = 0, row counter = 0;
  - next state DRAW (or DONE directly if w==0 or h==0).
  At most one grant per cycle.
- DRAW: one pixel per edge, raster order (column fastest, then row).
  - Pixel coordinates are computed at XW+1 and YW+1 bits (no wrap).
  - px = x0+col, py = y0+row; plot = 1 only if px < SCREEN_W and py < SCREEN_H.
  - A clipped pixel still consumes its cycle, with plot=0 and x/y/colour don't-care.
  - After pixel (w-1, h-1), next state DONE.
- DONE: done[g] = 1 for one cycle, plot = 0, rr pointer = (g+1) mod NUM_CH, next state IDLE.
- Timing: with ack at edge k, pixel n (0-based) is output at edge k+1+n, done is at edge k+1+w*h, and the earliest next ack is at edge k+2+w*h. For w or h = 0, done is at edge k+1.
- Handshake:
  - A requester may drop req any time after ack; parameters are held internally.
  - req changes while not granted are ignored until the next IDLE sample.
  - Holding req after done produces a new grant, subject to round-robin.
- Simultaneous requests: the lower index wins only relative to the rr pointer, so every channel is served within NUM_CH grants.
- plot is never high in IDLE or DONE.

Test Plan:
- Reset mid-draw: ch0 grant (x=5,y=110,w=16,h=2), assert resetn=0 after 10 pixels -> all outputs 0 immediately, no done[0], IDLE after release.
- Single request: ch0 (x=5,y=110,w=16,h=2,colour=7) -> ack[0] at edge k; 32 plots (5..20,110) then (5..20,111) at k+1..k+32; done[0] at k+33.
- Round-robin: ch1 and ch3 held high, rr=0, each w=h=1 -> grants ch1, ch3, ch1, ch3; each done precedes the next ack by one cycle.
- Clipping: ch2 (x=155,y=118,w=8,h=4) -> 32 pixel cycles, plot=1 only for x 155..159 and y 118..119 (10 pixels); done at k+33; no x wrap to 0..2.
- Zero size: ch0 w=0,h=5 -> ack then done one cycle later, plot never asserted.
- Request dropped after ack: ch1 req pulsed for one cycle with w=4,h=1, inputs changed afterwards -> 4 pixels drawn with the latched values.
